// File: rtl/xlib_avalon_bus_r.sv
// Read-side Avalon-MM burst arbiter: fixed-priority grant of NW requesters onto one
// pipelined burst-read master, with an in-order tracking FIFO that steers return beats.
module xlib_avalon_bus_r #(
  parameter int NW = 4,
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int BL = 8,
  parameter int OD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [NW-1:0]    s_rrdy,
  input  logic [NW-1:0]    s_rval,
  input  logic [NW*BL-1:0] s_rlen,
  input  logic [NW*AW-1:0] s_raddr,
  output logic [NW-1:0]    s_rdval,
  output logic [DW-1:0]    s_rdata,
  input  logic             m_rrdy,
  output logic             m_rval,
  output logic [BL-1:0]    m_rlen,
  output logic [AW-1:0]    m_raddr,
  input  logic             m_rdval,
  input  logic [DW-1:0]    m_rdata
);

  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int PW = (OD > 1) ? $clog2(OD) : 1;
  localparam int CW = PW + 1;

  // Handshake: a command transfers on a cycle where valid and ready are both high;
  // the requester holds valid/len/addr stable until then. Grant is recomputed every
  // cycle, so a higher port raising valid during a stall takes over the grant.

  logic [IW-1:0] w_rid;
  logic          w_any;
  logic          w_full;
  logic          w_push;
  logic          w_beat;
  logic          w_last;
  logic [IW-1:0] w_head_id;
  logic [BL-1:0] w_head_len;

  logic [IW-1:0] r_fid  [OD];
  logic [BL-1:0] r_flen [OD];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [BL-1:0] r_rcnt;
  logic [NW-1:0] r_rdval;
  logic [DW-1:0] r_rdata;

  // Later iterations overwrite earlier ones, so the highest valid index wins.
  always_comb begin
    w_rid = '0;
    for (int i = 0; i < NW; i++) begin
      if (s_rval[i]) w_rid = IW'(i);
    end
  end

  assign w_any   = |s_rval;
  assign w_full  = (r_count == CW'(OD));
  assign m_rval  = w_any & ~w_full;
  assign m_rlen  = s_rlen[w_rid*BL +: BL];
  assign m_raddr = s_raddr[w_rid*AW +: AW];
  assign s_rrdy  = (m_rrdy & ~w_full & w_any) ? (NW'(1) << w_rid) : '0;
  assign w_push  = m_rval & m_rrdy;

  assign w_head_id  = r_fid[r_rptr];
  assign w_head_len = r_flen[r_rptr];
  // Beats with nothing outstanding are dropped without touching any state.
  assign w_beat     = m_rdval & (r_count != '0);
  assign w_last     = w_beat & (r_rcnt == w_head_len);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fid[r_wptr]  <= w_rid;
      r_flen[r_wptr] <= m_rlen;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_last) r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_last})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // rcnt counts 1..len; returning to 1 on the last beat lets the next burst's
  // first beat follow immediately against the new head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rcnt  <= BL'(1);
      r_rdval <= '0;
      r_rdata <= '0;
    end else begin
      if (w_last)      r_rcnt <= BL'(1);
      else if (w_beat) r_rcnt <= r_rcnt + BL'(1);
      r_rdval <= w_beat ? (NW'(1) << w_head_id) : '0;
      if (w_beat) r_rdata <= m_rdata;
    end
  end

  assign s_rdval = r_rdval;
  assign s_rdata = r_rdata;

`ifndef SYNTHESIS
  a_rlen_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
    m_rval |-> (m_rlen != '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    w_push |-> (r_count < CW'(OD)));
`endif

endmodule

// File: tb/tb_xlib_avalon_bus_r.sv
// Bench for xlib_avalon_bus_r: directed scenarios then random traffic, checked
// against a queue-level model of outstanding bursts and an expected-beat scoreboard.
module tb_xlib_avalon_bus_r;
  localparam int NW = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BL = 8;
  localparam int OD = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NW-1:0]    s_rrdy;
  logic [NW-1:0]    s_rval;
  logic [NW*BL-1:0] s_rlen;
  logic [NW*AW-1:0] s_raddr;
  logic [NW-1:0]    s_rdval;
  logic [DW-1:0]    s_rdata;
  logic             m_rrdy;
  logic             m_rval;
  logic [BL-1:0]    m_rlen;
  logic [AW-1:0]    m_raddr;
  logic             m_rdval;
  logic [DW-1:0]    m_rdata;

  xlib_avalon_bus_r #(.NW(NW), .DW(DW), .AW(AW), .BL(BL), .OD(OD)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_rrdy(s_rrdy), .s_rval(s_rval), .s_rlen(s_rlen), .s_raddr(s_raddr),
    .s_rdval(s_rdval), .s_rdata(s_rdata),
    .m_rrdy(m_rrdy), .m_rval(m_rval), .m_rlen(m_rlen), .m_raddr(m_raddr),
    .m_rdval(m_rdval), .m_rdata(m_rdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int rem;
  } burst_t;

  burst_t              bq[$];
  logic [NW+DW-1:0]    exp_q[$];
  bit                  pend [NW];
  logic [BL-1:0]       plen [NW];
  logic [AW-1:0]       padr [NW];
  int                  vectors = 0;
  int                  miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add_req(input int p, input int len, input logic [AW-1:0] addr);
    pend[p] = 1'b1;
    plen[p] = BL'(len);
    padr[p] = addr;
  endtask

  task automatic drive_ports();
    for (int i = 0; i < NW; i++) begin
      s_rval[i]           = pend[i];
      s_rlen[i*BL +: BL]  = plen[i];
      s_raddr[i*AW +: AW] = padr[i];
    end
  endtask

  // One cycle: drive at negedge, check the combinational command path, then
  // advance the model using the outstanding list as it stood at the cycle start.
  task automatic step(input bit rrdy, input bit beat);
    int            g;
    bit            full;
    logic [DW-1:0] d;
    burst_t        h;
    @(negedge clk);
    drive_ports();
    d       = $urandom;
    m_rrdy  = rrdy;
    m_rdval = beat;
    m_rdata = d;
    #1;
    full = (bq.size() == OD);
    g = -1;
    for (int i = 0; i < NW; i++) if (pend[i]) g = i;
    if (g < 0) begin
      chk("m_rval_idle", 64'(m_rval), 64'(0));
      chk("s_rrdy_idle", 64'(s_rrdy), 64'(0));
    end else begin
      chk("m_rval", 64'(m_rval), 64'(!full));
      chk("s_rrdy", 64'(s_rrdy), (rrdy && !full) ? 64'(1 << g) : 64'(0));
      if (!full) begin
        chk("m_rlen", 64'(m_rlen), 64'(plen[g]));
        chk("m_raddr", 64'(m_raddr), 64'(padr[g]));
      end
    end
    if (beat && bq.size() > 0) begin
      h = bq[0];
      exp_q.push_back({NW'(1 << h.id), d});
      h.rem--;
      if (h.rem == 0) void'(bq.pop_front());
      else bq[0] = h;
    end
    if (g >= 0 && rrdy && !full) begin
      bq.push_back('{id: g, rem: int'(plen[g])});
      pend[g] = 1'b0;
    end
  endtask

  // scoreboard monitor: every beat shows up exactly one cycle after it was driven
  initial begin
    logic [NW+DW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("s_rdval", 64'(s_rdval), 64'(e[NW+DW-1:DW]));
        chk("s_rdata", 64'(s_rdata), 64'(e[DW-1:0]));
      end else begin
        chk("s_rdval_quiet", 64'(s_rdval), 64'(0));
      end
    end
  end

  initial begin
    bit busy;
    int guard;
    rst_n   = 1'b0;
    m_rrdy  = 1'b0;
    m_rdval = 1'b0;
    m_rdata = '0;
    for (int i = 0; i < NW; i++) begin
      pend[i] = 1'b0;
      plen[i] = BL'(1);
      padr[i] = '0;
    end
    drive_ports();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_rdval", 64'(s_rdval), 64'(0));
    chk("reset_rrdy", 64'(s_rrdy), 64'(0));
    chk("reset_mrval", 64'(m_rval), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // single request, port 1, len 4
    add_req(1, 4, 32'h100);
    step(1, 0);
    repeat (4) step(0, 1);
    step(0, 0);

    // priority: port 3 beats port 0
    add_req(0, 2, 32'h400);
    add_req(3, 1, 32'h300);
    step(1, 0);
    step(1, 0);
    repeat (3) step(0, 1);

    // stall with port 2 waiting
    add_req(2, 2, 32'h200);
    repeat (3) step(0, 0);
    step(1, 0);
    repeat (2) step(0, 1);

    // outstanding limit and conservative full throttling
    repeat (OD) begin
      add_req(0, 1, $urandom);
      step(1, 0);
    end
    add_req(1, 1, 32'h500);
    step(1, 0);
    step(1, 1);
    step(1, 1);
    repeat (OD + 1) step(0, 1);

    // back-to-back bursts with contiguous beats, plus stray beats on empty
    add_req(0, 2, 32'h600);
    step(1, 0);
    add_req(1, 3, 32'h700);
    step(1, 0);
    repeat (7) step(0, 1);

    // reset in the middle of a burst
    add_req(1, 4, 32'h800);
    step(1, 0);
    step(0, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_rdval", 64'(s_rdval), 64'(0));
    bq.delete();
    exp_q.delete();
    rst_n = 1'b1;
    repeat (3) step(1, 1);
    add_req(2, 3, 32'h900);
    step(1, 0);
    repeat (3) step(0, 1);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      bit b;
      for (int i = 0; i < NW; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0)
          add_req(i, $urandom_range(1, 6), $urandom);
      end
      b = (bq.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
      step($urandom_range(0, 3) != 0, b);
    end

    // drain everything still pending or outstanding, bounded
    guard = 0;
    busy  = 1'b1;
    while (busy && guard < 2000) begin
      step(1, 1);
      guard++;
      busy = (bq.size() > 0);
      for (int i = 0; i < NW; i++) if (pend[i]) busy = 1'b1;
    end
    chk("drain_bound", 64'(busy), 64'(0));
    step(0, 0);
    step(0, 0);
    chk("exp_q_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
